// File: rtl/camera_ctrl_pkg.sv
// Shared types and readout-phase constants for the multi-row camera controller.
package camera_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ERASE   = 2'd1,
        ST_EXPOSE  = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    localparam logic [1:0] PH_P0 = 2'd0;
    localparam logic [1:0] PH_P1 = 2'd1;
    localparam logic [1:0] PH_P2 = 2'd2;
    localparam logic [1:0] PH_P3 = 2'd3;

    localparam int READOUT_PHASES = 4;

endpackage

// File: rtl/camera_ctrl_multirow_if.sv
// User-control and pixel-array bundle of the camera controller.
// frame_count exists only when CAM_CTRL_FRAME_CNT_EN is defined.
interface camera_ctrl_multirow_if #(
    parameter int NUM_ROWS = 2,
    parameter int EXP_W    = 5
);
    logic                init;
    logic                exp_increase;
    logic                exp_decrease;
    logic                continuous;
    logic [NUM_ROWS-1:0] nre;
    logic                adc;
    logic                expose;
    logic                erase;
    logic                busy;
    logic [EXP_W-1:0]    exp_time;
`ifdef CAM_CTRL_FRAME_CNT_EN
    logic [15:0]         frame_count;

    modport master (
        output init, exp_increase, exp_decrease, continuous,
        input  nre, adc, expose, erase, busy, exp_time, frame_count
    );
    modport slave (
        input  init, exp_increase, exp_decrease, continuous,
        output nre, adc, expose, erase, busy, exp_time, frame_count
    );
`else
    modport master (
        output init, exp_increase, exp_decrease, continuous,
        input  nre, adc, expose, erase, busy, exp_time
    );
    modport slave (
        input  init, exp_increase, exp_decrease, continuous,
        output nre, adc, expose, erase, busy, exp_time
    );
`endif
endinterface

// File: rtl/camera_exp_adjust.sv
// Exposure-time register: rising-edge step up/down, saturating at EXP_MIN..EXP_MAX,
// applied only while en_i is high.
module camera_exp_adjust #(
    parameter int EXP_W    = 5,
    parameter int EXP_MIN  = 2,
    parameter int EXP_MAX  = 30,
    parameter int EXP_INIT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [EXP_W-1:0] exp_time_o
);
    localparam logic [EXP_W-1:0] MIN_V  = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] MAX_V  = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] INIT_V = EXP_W'(EXP_INIT);

    logic             inc_prev_q, dec_prev_q;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             inc_rise, dec_rise;

    assign inc_rise = inc_i & ~inc_prev_q;
    assign dec_rise = dec_i & ~dec_prev_q;

    // Edges outside the enable window are consumed by the history registers, never queued.
    always_comb begin
        exp_d = exp_q;
        if (en_i && inc_rise && !dec_rise && (exp_q < MAX_V))
            exp_d = exp_q + 1'b1;
        else if (en_i && dec_rise && !inc_rise && (exp_q > MIN_V))
            exp_d = exp_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
            exp_q      <= INIT_V;
        end else begin
            inc_prev_q <= inc_i;
            dec_prev_q <= dec_i;
            exp_q      <= exp_d;
        end
    end

    assign exp_time_o = exp_q;
endmodule

// File: rtl/camera_ctrl_multirow.sv
// Camera sequencer: erase, timed exposure, then 4-phase readout of NUM_ROWS rows.
// Optional frame counter enabled by defining CAM_CTRL_FRAME_CNT_EN.
//
//   state      | meaning
//   ST_IDLE    | waiting for init; exposure adjust enabled
//   ST_ERASE   | erase high for ERASE_CYCLES
//   ST_EXPOSE  | expose high for exp_time*TICK_CYCLES
//   ST_READOUT | rows 0..NUM_ROWS-1, phases P0..P3 each
module camera_ctrl_multirow
    import camera_ctrl_pkg::*;
#(
    parameter int NUM_ROWS     = 2,
    parameter int EXP_W        = 5,
    parameter int EXP_MIN      = 2,
    parameter int EXP_MAX      = 30,
    parameter int EXP_INIT     = 10,
    parameter int TICK_CYCLES  = 4,
    parameter int ERASE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    camera_ctrl_multirow_if.slave  bus
);
    localparam int CNT_W = $clog2(EXP_MAX * TICK_CYCLES + ERASE_CYCLES + 1);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ROW_W-1:0]    row_q;
    logic [1:0]          phase_q;
    logic [NUM_ROWS-1:0] nre_q;
    logic                adc_q, expose_q, erase_q, busy_q;
    logic [EXP_W-1:0]    exp_time;
    logic [CNT_W-1:0]    exp_load;
`ifdef CAM_CTRL_FRAME_CNT_EN
    logic [15:0]         frame_cnt_q;
`endif

    function automatic logic [NUM_ROWS-1:0] row_nre(input logic [ROW_W-1:0] r);
        return ~(NUM_ROWS'(1) << r);
    endfunction

    camera_exp_adjust #(
        .EXP_W   (EXP_W),
        .EXP_MIN (EXP_MIN),
        .EXP_MAX (EXP_MAX),
        .EXP_INIT(EXP_INIT)
    ) u_exp_adjust (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ST_IDLE),
        .inc_i     (bus.exp_increase),
        .dec_i     (bus.exp_decrease),
        .exp_time_o(exp_time)
    );

    // Loading the down-counter on entry to EXPOSE is what latches the exposure time.
    assign exp_load = CNT_W'(32'(exp_time) * TICK_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            phase_q  <= PH_P0;
            nre_q    <= '1;
            adc_q    <= 1'b0;
            expose_q <= 1'b0;
            erase_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CAM_CTRL_FRAME_CNT_EN
            frame_cnt_q <= 16'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.init) begin
                        state_q <= ST_ERASE;
                        erase_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= ERASE_LOAD;
                    end
                end
                ST_ERASE: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_EXPOSE;
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                        cnt_q    <= exp_load;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_EXPOSE: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_READOUT;
                        expose_q <= 1'b0;
                        row_q    <= '0;
                        phase_q  <= PH_P0;
                        nre_q    <= row_nre('0);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_READOUT: begin
                    case (phase_q)
                        PH_P0: begin
                            phase_q <= PH_P1;
                            adc_q   <= 1'b1;
                        end
                        PH_P1: begin
                            phase_q <= PH_P2;
                            adc_q   <= 1'b0;
                        end
                        PH_P2: begin
                            phase_q <= PH_P3;
                            nre_q   <= '1;
                        end
                        default: begin
                            if (row_q != LAST_ROW) begin
                                row_q   <= row_q + 1'b1;
                                phase_q <= PH_P0;
                                nre_q   <= row_nre(row_q + 1'b1);
                            end else begin
`ifdef CAM_CTRL_FRAME_CNT_EN
                                frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                                // continuous is only looked at here, at the very end of the frame
                                if (bus.continuous) begin
                                    state_q <= ST_ERASE;
                                    erase_q <= 1'b1;
                                    cnt_q   <= ERASE_LOAD;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    endcase
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.nre      = nre_q;
    assign bus.adc      = adc_q;
    assign bus.expose   = expose_q;
    assign bus.erase    = erase_q;
    assign bus.busy     = busy_q;
    assign bus.exp_time = exp_time;
`ifdef CAM_CTRL_FRAME_CNT_EN
    assign bus.frame_count = frame_cnt_q;
`endif
endmodule
